my_logic_pipe: RTL and testbench
================================

MY_LOGIC_PIPE -- requirements
Module: my_logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal 1..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising edge of clock.
REQ-005 SHALL have port in_valid, input, 1, request carries valid operands.
REQ-006 SHALL have port in_ready, output, 1, block accepts request this cycle.
REQ-007 SHALL have port op, input, 2, operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 SHALL have port opA, input, WIDTH, first operand.
REQ-009 SHALL have port opB, input, WIDTH, second operand.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result this cycle.
REQ-012 SHALL have port cout, output, WIDTH, bitwise result.
REQ-013 SHALL have port is_zero, output, 1, high when cout is all zeros.
REQ-014 SHALL have port op_count, output, CNT_W, number of results accepted by consumer since reset.

Function
REQ-015 SHALL transfer input when in_valid and in_ready both high on a rising edge; output transfer when out_valid and out_ready both high.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers op/opA/opB; stage 2 registers computed cout and is_zero.
REQ-017 SHALL produce out_valid exactly 2 cycles after input transfer when no backpressure is present.
REQ-018 SHALL sustain one transfer per cycle with out_ready held high.
REQ-019 SHALL advance stage 2 when stage 2 is empty or its result transfers in the same cycle; stage 1 advances under the same rule applied to stage 1.
REQ-020 SHALL drive in_ready = !s1_valid | !s2_valid | out_ready, combinationally; in_ready SHALL not depend on in_valid.
REQ-021 SHALL hold cout, is_zero and out_valid stable while out_valid high and out_ready low.
REQ-022 SHALL never drop, duplicate or reorder results; with both stages full and out_ready low, in_ready SHALL be low.
REQ-023 SHALL compute each bit independently: cout[i] = f(op, opA[i], opB[i]) for all i < WIDTH.
REQ-024 SHALL increment op_count by 1 per output transfer and saturate at 2^CNT_W-1 (no wrap).
REQ-025 SHALL keep cout and is_zero at their last values when out_valid low; value is don't-care for verification.

Reset
REQ-026 SHALL on reset clear both stage valid flags, flushing in-flight data without producing output.
REQ-027 SHALL reset out_valid to 0, cout to 0, is_zero to 1, op_count to 0; in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-028 SHALL ignore in_valid during reset cycles; reset SHALL take priority over any simultaneous transfer.

Configuration
REQ-029 SHALL, when macro MY_LOGIC_PIPE_PARITY_EN is defined, add output port parity (1 bit) = XOR-reduction of cout, registered in stage 2 alongside cout, reset value 0, held under backpressure like cout.
REQ-030 SHALL, without MY_LOGIC_PIPE_PARITY_EN, have no parity port and no parity logic; all other behaviour identical.

Verification
REQ-031 Bench SHALL apply op=01, opA=0x0000_F0F0, opB=0x0F0F_0000, out_ready=1 -> cout=0x0F0F_F0F0, is_zero=0, out_valid exactly 2 cycles later.
REQ-032 Bench SHALL stream 4 back-to-back ops (AND, OR, XOR, NOR on opA=0xFFFF_0000, opB=0xFF00_FF00) -> results 0xFF00_0000, 0xFFFF_FF00, 0x00FF_FF00, 0x0000_00FF on consecutive cycles, op_count=4.
REQ-033 Bench SHALL hold out_ready=0 while sending 3 requests -> 2 accepted, in_ready low on third, cout stable; release out_ready -> all 3 results in order.
REQ-034 Bench SHALL apply op=10, opA=opB=0xDEAD_BEEF -> cout=0, is_zero=1 (and parity=0 with MY_LOGIC_PIPE_PARITY_EN).
REQ-035 Bench SHALL assert reset for 1 cycle with both stages full -> out_valid=0, op_count=0 next cycle, flushed data never appears.
REQ-036 Bench SHALL run CNT_W=2 with 5 transfers -> op_count=3 after the 3rd and remains 3.

Source files
------------

// File: rtl/my_logic_pipe.sv
// Two-stage bitwise logic pipeline (AND/OR/XOR/NOR) with valid/ready flow control
// and a saturating completed-operation counter. Define MY_LOGIC_PIPE_PARITY_EN to add a parity output.
module my_logic_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] cout,
   output logic             is_zero,
   output logic [CNT_W-1:0] op_count
`ifdef MY_LOGIC_PIPE_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // Ready never looks at valid; a stage moves when it is empty or its occupant leaves this cycle.

   logic             s1_valid_q, s1_valid_d;
   logic [1:0]       s1_op_q,    s1_op_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] cout_q,     cout_d;
   logic             zero_q,     zero_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
`ifdef MY_LOGIC_PIPE_PARITY_EN
   logic             parity_q,   parity_d;
`endif

   logic             s1_adv;
   logic             s2_adv;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] result;

   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_fire  = in_valid && s1_adv;
      out_fire = s2_valid_q && out_ready;
   end

   always_comb begin
      result = '0;
      case (s1_op_q)
         OP_AND:  result = s1_a_q & s1_b_q;
         OP_OR:   result = s1_a_q | s1_b_q;
         OP_XOR:  result = s1_a_q ^ s1_b_q;
         default: result = ~(s1_a_q | s1_b_q);
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      cout_d     = cout_q;
      zero_d     = zero_q;
      cnt_d      = cnt_q;
`ifdef MY_LOGIC_PIPE_PARITY_EN
      parity_d   = parity_q;
`endif

      if (s1_adv) begin
         s1_valid_d = in_valid;
      end
      if (in_fire) begin
         s1_op_d = op;
         s1_a_d  = opA;
         s1_b_d  = opB;
      end

      // Result registers only load on a real stage-1 hand-off, so they hold their last value when idle.
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            cout_d   = result;
            zero_d   = ~|result;
`ifdef MY_LOGIC_PIPE_PARITY_EN
            parity_d = ^result;
`endif
         end
      end

      if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= 2'b00;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         cout_q     <= '0;
         zero_q     <= 1'b1;
         cnt_q      <= '0;
`ifdef MY_LOGIC_PIPE_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         cout_q     <= cout_d;
         zero_q     <= zero_d;
         cnt_q      <= cnt_d;
`ifdef MY_LOGIC_PIPE_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign cout      = cout_q;
   assign is_zero   = zero_q;
   assign op_count  = cnt_q;
`ifdef MY_LOGIC_PIPE_PARITY_EN
   assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_my_logic_pipe.sv
// Self-checking bench for my_logic_pipe: vector table, scoreboard queue and
// hand-written backpressure/reset sequences; a CNT_W=2 twin checks counter saturation.
module tb_my_logic_pipe;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] opA;
   logic [31:0] opB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] cout;
   logic        is_zero;
   logic [15:0] op_count;

   logic        in_ready2;
   logic        out_valid2;
   logic [31:0] cout2;
   logic        is_zero2;
   logic [1:0]  op_count2;
`ifdef MY_LOGIC_PIPE_PARITY_EN
   logic        parity;
   logic        parity2;
`endif

   my_logic_pipe #(.WIDTH(32), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .opA(opA), .opB(opB), .out_valid(out_valid), .out_ready(out_ready),
      .cout(cout), .is_zero(is_zero), .op_count(op_count)
`ifdef MY_LOGIC_PIPE_PARITY_EN
      , .parity(parity)
`endif
   );

   my_logic_pipe #(.WIDTH(32), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .op(op), .opA(opA), .opB(opB), .out_valid(out_valid2), .out_ready(out_ready),
      .cout(cout2), .is_zero(is_zero2), .op_count(op_count2)
`ifdef MY_LOGIC_PIPE_PARITY_EN
      , .parity(parity2)
`endif
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   int pops = 0;
   int streak = 0;
   int last_pop_cyc = -10;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   // scoreboard: outputs popped and compared, counters compared against accepted-output model
   always @(negedge clock) begin
      if (!reset) begin
         check("op_count", 64'(op_count), 64'(pops));
         check("op_count_sat", 64'(op_count2), 64'((pops > 3) ? 3 : pops));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'(cout), 64'hDEAD_0000_0000_0000);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("cout", 64'(cout), 64'(e));
               check("is_zero", 64'(is_zero), 64'(e == 32'h0));
`ifdef MY_LOGIC_PIPE_PARITY_EN
               check("parity", 64'(parity), 64'(^e));
`endif
            end
            if (cyc == last_pop_cyc + 1) streak++;
            else streak = 1;
            last_pop_cyc = cyc;
            pops++;
         end
      end
   end

   // driver tasks; every task starts and ends 1 time unit after a rising edge
   task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      int t;
      in_valid = 1'b1;
      op = o;
      opA = a;
      opB = b;
      t = 0;
      @(negedge clock);
      while (!in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
      else exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset(input int n);
      reset = 1'b1;
      in_valid = 1'b1;
      op = 2'd1;
      opA = 32'h1234_5678;
      opB = 32'h0F0F_0F0F;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      pops = 0;
      streak = 0;
      last_pop_cyc = -10;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clock);
         t++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_state(input string nm);
      @(negedge clock);
      check({nm, "_out_valid"}, 64'(out_valid), 64'd0);
      check({nm, "_cout"}, 64'(cout), 64'd0);
      check({nm, "_is_zero"}, 64'(is_zero), 64'd1);
      check({nm, "_op_count"}, 64'(op_count), 64'd0);
      check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
`ifdef MY_LOGIC_PIPE_PARITY_EN
      check({nm, "_parity"}, 64'(parity), 64'd0);
`endif
      @(posedge clock);
      #1;
   endtask

   logic bp_active;

   initial begin
      vecs[0] = '{2'd0, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFF00_0000};
      vecs[1] = '{2'd1, 32'hFFFF_0000, 32'hFF00_FF00, 32'hFFFF_FF00};
      vecs[2] = '{2'd2, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
      vecs[3] = '{2'd3, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0000_00FF};
      vecs[4] = '{2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[5] = '{2'd1, 32'h0000_F0F0, 32'h0F0F_0000, 32'h0F0F_F0F0};
      vecs[6] = '{2'd0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{2'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
      vecs[8] = '{2'd0, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
      vecs[9] = '{2'd2, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F0};

      in_valid = 1'b0;
      op = 2'd0;
      opA = '0;
      opB = '0;
      out_ready = 1'b1;
      bp_active = 1'b0;

      // power-on reset with in_valid high: nothing may be accepted
      pulse_reset(3);
      check_reset_state("reset");
      repeat (3) begin
         @(negedge clock);
         check("no_output_after_reset", 64'(out_valid), 64'd0);
         @(posedge clock);
         #1;
      end

      // single OR: out_valid two cycles after the transfer
      send(vecs[5].op, vecs[5].a, vecs[5].b, vecs[5].exp);
      in_valid = 1'b0;
      @(negedge clock);
      check("latency_cycle1", 64'(out_valid), 64'd0);
      @(posedge clock);
      @(negedge clock);
      check("latency_cycle2", 64'(out_valid), 64'd1);
      check("latency_cout", 64'(cout), 64'h0F0F_F0F0);
      @(posedge clock);
      #1;
      drain();

      // four back-to-back ops from a fresh reset
      pulse_reset(1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      in_valid = 1'b0;
      drain();
      check("b2b_consecutive", 64'(streak), 64'd4);
      check("b2b_op_count", 64'(op_count), 64'd4);
      check("b2b_op_count_sat", 64'(op_count2), 64'd3);

      // remaining table vectors, streamed
      for (int i = 4; i < 10; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      in_valid = 1'b0;
      drain();
      check("table_op_count", 64'(op_count), 64'd10);
      check("sat_holds", 64'(op_count2), 64'd3);

      // backpressure: two accepted, third stalls, output held
      out_ready = 1'b0;
      send(vecs[5].op, vecs[5].a, vecs[5].b, vecs[5].exp);
      send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].exp);
      in_valid = 1'b1;
      op = vecs[7].op;
      opA = vecs[7].a;
      opB = vecs[7].b;
      repeat (3) begin
         @(negedge clock);
         check("bp_in_ready_low", 64'(in_ready), 64'd0);
         check("bp_out_valid_held", 64'(out_valid), 64'd1);
         check("bp_cout_held", 64'(cout), 64'h0F0F_F0F0);
         check("bp_is_zero_held", 64'(is_zero), 64'd0);
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      send(vecs[7].op, vecs[7].a, vecs[7].b, vecs[7].exp);
      in_valid = 1'b0;
      drain();

      // reset with both stages full: flushed data must never appear
      out_ready = 1'b0;
      send(vecs[8].op, vecs[8].a, vecs[8].b, vecs[8].exp);
      send(vecs[9].op, vecs[9].a, vecs[9].b, vecs[9].exp);
      in_valid = 1'b0;
      @(negedge clock);
      check("full_before_reset", 64'(in_ready), 64'd0);
      @(posedge clock);
      #1;
      pulse_reset(1);
      check_reset_state("flush");
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clock);
         check("flushed_absent", 64'(out_valid), 64'd0);
         @(posedge clock);
         #1;
      end

      // random traffic with random backpressure
      bp_active = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               logic [1:0]  ro;
               logic [31:0] ra;
               logic [31:0] rb;
               ro = 2'($urandom_range(0, 3));
               ra = $urandom;
               rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
               send(ro, ra, rb, model(ro, ra, rb));
               if ($urandom_range(0, 3) == 0) begin
                  in_valid = 1'b0;
                  @(posedge clock);
                  #1;
               end
            end
            in_valid = 1'b0;
            bp_active = 1'b0;
         end
         begin
            while (bp_active) begin
               @(posedge clock);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check("random_op_count", 64'(op_count), 64'(pops));
      check("random_sat", 64'(op_count2), 64'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
